blinky_pwm_bank: RTL and testbench

BLINKY_PWM_BANK -- requirements
Module: blinky_pwm_bank

---
 rtl/blinky_pkg.sv | 23 ++
 rtl/blinky_chan.sv | 60 ++++++
 rtl/blinky_pwm_bank.sv | 84 ++++++++
 tb/tb_blinky_pwm_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/blinky_pkg.sv
// Shared mode encodings and the per-channel LED decision for the blinky PWM bank.
package blinky_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  // below: phase is under the duty threshold; blinkOn: current blink half-period is lit
  function automatic logic led_level(input mode_e mode, input logic below, input logic blinkOn);
    logic lvl;
    case (mode)
      MODE_ON:    lvl = 1'b1;
      MODE_PWM:   lvl = below;
      MODE_BLINK: lvl = below & blinkOn;
      default:    lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/blinky_chan.sv
// One LED channel: shadow config taking writes, active config reloaded at period end,
// and a registered compare against the shared phase counter.
module blinky_chan
  import blinky_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_phase,
  input  logic             i_blink,
  output logic             o_led
);

  mode_e            shadowMode_q, shadowMode_d;
  mode_e            activeMode_q, activeMode_d;
  logic [WIDTH-1:0] shadowDuty_q, shadowDuty_d;
  logic [WIDTH-1:0] activeDuty_q, activeDuty_d;
  logic             led_q, led_d;

  // A write landing on the load cycle stays in shadow; active takes the pre-write shadow.
  always_comb begin
    shadowMode_d = shadowMode_q;
    shadowDuty_d = shadowDuty_q;
    activeMode_d = activeMode_q;
    activeDuty_d = activeDuty_q;
    if (i_wr) begin
      shadowMode_d = mode_e'(i_mode);
      shadowDuty_d = i_duty;
    end
    if (i_load) begin
      activeMode_d = shadowMode_q;
      activeDuty_d = shadowDuty_q;
    end
    led_d = led_level(activeMode_q, (i_phase < activeDuty_q), i_blink);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadowMode_q <= MODE_OFF;
      shadowDuty_q <= '0;
      activeMode_q <= MODE_OFF;
      activeDuty_q <= '0;
      led_q        <= 1'b0;
    end else begin
      shadowMode_q <= shadowMode_d;
      shadowDuty_q <= shadowDuty_d;
      activeMode_q <= activeMode_d;
      activeDuty_q <= activeDuty_d;
      led_q        <= led_d;
    end
  end

  assign o_led = led_q;

endmodule

// File: rtl/blinky_pwm_bank.sv
// Bank of NCH LED channels sharing one prescaled PWM phase counter and a blink counter;
// channel config is double-buffered so changes only take effect at a period boundary.
module blinky_pwm_bank
  import blinky_pkg::*;
#(
  parameter  int NCH        = 4,
  parameter  int WIDTH      = 8,
  parameter  int PRESCALE   = 16,
  parameter  int BLINK_BITS = 4,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic [CHW-1:0]   i_ch,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_duty,
  output logic             o_ack,
  output logic             o_err,
  output logic [NCH-1:0]   o_led,
  output logic [WIDTH-1:0] o_counter,
  output logic             o_period
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSW-1:0]        presc_q, presc_d;
  logic [WIDTH-1:0]      phase_q, phase_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  period_q, ack_q, err_q;
  logic                  step, periodEnd, chValid;
  logic [NCH-1:0]        ledBits;

  // With PRESCALE=1 the prescaler sits at 0 and every cycle is a step.
  always_comb begin
    step      = (presc_q == PSW'(PRESCALE - 1));
    presc_d   = step ? '0 : presc_q + PSW'(1);
    phase_d   = step ? phase_q + WIDTH'(1) : phase_q;
    periodEnd = step && (&phase_q);
    blink_d   = periodEnd ? blink_q + BLINK_BITS'(1) : blink_q;
    chValid   = (32'(i_ch) < NCH);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q  <= '0;
      phase_q  <= '0;
      blink_q  <= '0;
      period_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      blink_q  <= blink_d;
      period_q <= periodEnd;
      ack_q    <= i_wr && chValid;
      err_q    <= i_wr && !chValid;
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : gChan
    blinky_chan #(
      .WIDTH(WIDTH)
    ) uChan (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_wr   (i_wr && (i_ch == CHW'(n))),
      .i_mode (i_mode),
      .i_duty (i_duty),
      .i_load (periodEnd),
      .i_phase(phase_q),
      .i_blink(blink_q[BLINK_BITS-1]),
      .o_led  (ledBits[n])
    );
  end

  assign o_led     = ledBits;
  assign o_counter = phase_q;
  assign o_period  = period_q;
  assign o_ack     = ack_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_blinky_pwm_bank.sv
// Directed bench for blinky_pwm_bank: reset, config writes, per-period LED duty counts,
// shadow timing, blink cadence and mid-run reset.
module tb_blinky_pwm_bank;

  // NCH=5 so the 3-bit channel index can name channels that do not exist
  localparam int NCH        = 5;
  localparam int WIDTH      = 8;
  localparam int PRESCALE   = 4;
  localparam int BLINK_BITS = 2;
  localparam int CHW        = 3;
  localparam int PERIOD_CYC = 256 * PRESCALE;

  logic             clk;
  logic             i_reset;
  logic             i_wr;
  logic [CHW-1:0]   i_ch;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_duty;
  logic             o_ack;
  logic             o_err;
  logic [NCH-1:0]   o_led;
  logic [WIDTH-1:0] o_counter;
  logic             o_period;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           wr;
    logic [CHW-1:0] ch;
    logic [1:0]     mode;
    logic [7:0]     duty;
    logic           expAck;
    logic           expErr;
  } vec_t;

  vec_t vecs[8];
  int   expCnt[6][NCH];

  blinky_pwm_bank #(
    .NCH(NCH), .WIDTH(WIDTH), .PRESCALE(PRESCALE), .BLINK_BITS(BLINK_BITS)
  ) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_wr     (i_wr),
    .i_ch     (i_ch),
    .i_mode   (i_mode),
    .i_duty   (i_duty),
    .o_ack    (o_ack),
    .o_err    (o_err),
    .o_led    (o_led),
    .o_counter(o_counter),
    .o_period (o_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    i_wr   = vecs[idx].wr;
    i_ch   = vecs[idx].ch;
    i_mode = vecs[idx].mode;
    i_duty = vecs[idx].duty;
    tick;
    checkOutput($sformatf("vec%0d_ack", idx), int'(o_ack), int'(vecs[idx].expAck));
    checkOutput($sformatf("vec%0d_err", idx), int'(o_err), int'(vecs[idx].expErr));
  endtask

  task automatic waitPeriod;
    int k;
    for (k = 0; k < 2 * PERIOD_CYC; k++) begin
      tick;
      if (o_period) break;
    end
    checkOutput("period_seen", int'(o_period), 1);
  endtask

  // Counts LED-high cycles over one full period; optionally issues one write after sample wrAt.
  task automatic measurePeriod(input int p, input int wrAt, input logic [CHW-1:0] ch,
                               input logic [1:0] mode, input logic [7:0] duty);
    int cnt[NCH];
    int pcnt;
    for (int n = 0; n < NCH; n++) cnt[n] = 0;
    pcnt = 0;
    for (int k = 1; k <= PERIOD_CYC; k++) begin
      tick;
      for (int n = 0; n < NCH; n++) if (o_led[n]) cnt[n]++;
      if (o_period) pcnt++;
      if (wrAt >= 0 && k == wrAt + 1) begin
        checkOutput($sformatf("p%0d_ack", p), int'(o_ack), int'(ch < NCH));
        checkOutput($sformatf("p%0d_err", p), int'(o_err), int'(ch >= NCH));
      end
      i_wr   = (k == wrAt);
      i_ch   = ch;
      i_mode = mode;
      i_duty = duty;
    end
    i_wr = 1'b0;
    for (int n = 0; n < NCH; n++)
      checkOutput($sformatf("p%0d_ch%0d_high", p, n), cnt[n], expCnt[p-1][n]);
    checkOutput($sformatf("p%0d_period_pulses", p), pcnt, 1);
    checkOutput($sformatf("p%0d_period_at_end", p), int'(o_period), 1);
  endtask

  initial begin
    int ones;
    int perTick;

    vecs[0] = '{1'b1, 3'd0, 2'b10, 8'd64,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 3'd1, 2'b10, 8'd99,  1'b1, 1'b0};
    vecs[2] = '{1'b1, 3'd1, 2'b10, 8'd10,  1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd2, 2'b11, 8'd255, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 3'd5, 2'b01, 8'd0,   1'b0, 1'b1};
    vecs[5] = '{1'b1, 3'd3, 2'b01, 8'd0,   1'b1, 1'b0};
    vecs[6] = '{1'b1, 3'd7, 2'b10, 8'd128, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 3'd0, 2'b01, 8'd0,   1'b0, 1'b0};

    // ch0 PWM64, ch1 PWM10->200, ch2 BLINK255 (BLINK_BITS=2), ch3 ON->PWM0, ch4 never written
    expCnt[0] = '{256,  40,    0, 1024, 0};
    expCnt[1] = '{256,  800, 1020, 1024, 0};
    expCnt[2] = '{256,  800, 1020,    0, 0};
    expCnt[3] = '{256,  800,    0,    0, 0};
    expCnt[4] = '{1024, 800,    0,    0, 0};
    expCnt[5] = '{1024, 800, 1020,    0, 0};

    i_reset = 1'b1;
    i_wr    = 1'b1;
    i_ch    = 3'd4;
    i_mode  = 2'b01;
    i_duty  = 8'd0;
    repeat (3) tick;
    checkOutput("rst_led",     int'(o_led), 0);
    checkOutput("rst_counter", int'(o_counter), 0);
    checkOutput("rst_ack",     int'(o_ack), 0);
    checkOutput("rst_err",     int'(o_err), 0);
    checkOutput("rst_period",  int'(o_period), 0);

    i_reset = 1'b0;
    i_wr    = 1'b0;
    checkOutput("rel_counter_c0", int'(o_counter), 0);
    for (int i = 1; i <= 3; i++) begin
      tick;
      checkOutput($sformatf("rel_counter_c%0d", i), int'(o_counter), 0);
    end
    checkOutput("rel_ack", int'(o_ack), 0);
    tick;
    checkOutput("rel_counter_step", int'(o_counter), 1);

    for (int i = 0; i < 8; i++) applyStimulus(i);
    i_wr = 1'b0;
    tick;
    checkOutput("shadow_not_active", int'(o_led), 0);

    waitPeriod();
    measurePeriod(1, 500,  3'd1, 2'b10, 8'd200);
    measurePeriod(2, 300,  3'd3, 2'b10, 8'd0);
    measurePeriod(3, 1023, 3'd0, 2'b01, 8'd0);
    measurePeriod(4, 10,   3'd6, 2'b01, 8'd255);
    measurePeriod(5, -1,   3'd0, 2'b00, 8'd0);
    measurePeriod(6, -1,   3'd0, 2'b00, 8'd0);

    checkOutput("pre_reset_led0", int'(o_led[0]), 1);
    i_reset = 1'b1;
    #1;
    checkOutput("midrst_led",     int'(o_led), 0);
    checkOutput("midrst_counter", int'(o_counter), 0);
    checkOutput("midrst_period",  int'(o_period), 0);
    repeat (2) tick;
    i_reset = 1'b0;
    ones    = 0;
    perTick = -1;
    for (int k = 1; k <= PERIOD_CYC + 80; k++) begin
      tick;
      if (o_led != '0) ones++;
      if (o_period && perTick < 0) perTick = k;
    end
    checkOutput("postrst_led_cycles", ones, 0);
    checkOutput("postrst_first_period", perTick, PERIOD_CYC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
